// File: rtl/id_ex_hazard_reg_pkg.sv
// Shared types and default widths for the ID/EX pipeline register with branch flush and
// load-use bubble insertion.
package id_ex_hazard_reg_pkg;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_RD_W    = 5;
    localparam int unsigned DEF_ALU_W   = 5;
    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned FUNC3_W     = 3;
    localparam int unsigned IMM_FMT_W   = 7;
    localparam int unsigned WB_CTRL_W   = 2;
    // FLUSH_CYCLES is limited to 1..4, so the remaining-kill count never exceeds 3
    localparam int unsigned FLUSH_CNT_W = 2;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] imm;
        logic [DEF_DATA_W-1:0] op1;
        logic [DEF_DATA_W-1:0] op2;
        logic [DEF_ALU_W-1:0]  alu_ctrl;
        logic [DEF_DATA_W-1:0] rout2;
        logic [FUNC3_W-1:0]    func3;
        logic [IMM_FMT_W-1:0]  imm_fmt;
        logic [DEF_RD_W-1:0]   rd;
        logic                  rs1_valid;
        logic                  rs2_valid;
        logic                  we;
        logic [WB_CTRL_W-1:0]  wb_ctrl;
    } payload_t;

    localparam payload_t PAYLOAD_BUBBLE = '0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/id_ex_hazard_reg_sat_counter.sv
// Saturating up-counter used to count inserted pipeline bubbles.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register: kills ID instructions after a taken branch, inserts load-use
// bubbles, honours EX backpressure and counts every bubble it inserts.
module id_ex_hazard_reg
    import id_ex_hazard_reg_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned RD_W         = DEF_RD_W,
    parameter int unsigned ALU_W        = DEF_ALU_W,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [DATA_W-1:0]    id_imm,
    input  logic [DATA_W-1:0]    id_op1,
    input  logic [DATA_W-1:0]    id_op2,
    input  logic [ALU_W-1:0]     id_alu_ctrl,
    input  logic [DATA_W-1:0]    id_rout2,
    input  logic [FUNC3_W-1:0]   id_func3,
    input  logic [IMM_FMT_W-1:0] id_imm_fmt,
    input  logic [RD_W-1:0]      id_rd,
    input  logic                 id_rs1_valid,
    input  logic                 id_rs2_valid,
    input  logic                 id_we,
    input  logic [WB_CTRL_W-1:0] id_wb_ctrl,
    input  logic                 branch_taken,
    input  logic                 hazard_stall,
    input  logic                 ex_ready,
    output logic                 ex_valid,
    output logic [DATA_W-1:0]    ex_imm,
    output logic [DATA_W-1:0]    ex_op1,
    output logic [DATA_W-1:0]    ex_op2,
    output logic [ALU_W-1:0]     ex_alu_ctrl,
    output logic [DATA_W-1:0]    ex_rout2,
    output logic [FUNC3_W-1:0]   ex_func3,
    output logic [IMM_FMT_W-1:0] ex_imm_fmt,
    output logic [RD_W-1:0]      ex_rd,
    output logic                 ex_rs1_valid,
    output logic                 ex_rs2_valid,
    output logic                 ex_we,
    output logic [WB_CTRL_W-1:0] ex_wb_ctrl,
    output logic [CNT_W-1:0]     bubble_cnt
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam state_t                 BRANCH_ST  = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

    // Same field order as the package payload, sized by this instance's parameters
    typedef struct packed {
        logic [DATA_W-1:0]    imm;
        logic [DATA_W-1:0]    op1;
        logic [DATA_W-1:0]    op2;
        logic [ALU_W-1:0]     alu_ctrl;
        logic [DATA_W-1:0]    rout2;
        logic [FUNC3_W-1:0]   func3;
        logic [IMM_FMT_W-1:0] imm_fmt;
        logic [RD_W-1:0]      rd;
        logic                 rs1_valid;
        logic                 rs2_valid;
        logic                 we;
        logic [WB_CTRL_W-1:0] wb_ctrl;
    } ex_payload_t;

    state_t                 state;
    logic [FLUSH_CNT_W-1:0] flush_cnt;
    ex_payload_t            id_pl;
    ex_payload_t            ex_q;
    logic                   advance;
    logic                   bubble_inc;

    assign id_pl = '{imm: id_imm, op1: id_op1, op2: id_op2, alu_ctrl: id_alu_ctrl,
                     rout2: id_rout2, func3: id_func3, imm_fmt: id_imm_fmt, rd: id_rd,
                     rs1_valid: id_rs1_valid, rs2_valid: id_rs2_valid, we: id_we,
                     wb_ctrl: id_wb_ctrl};

    assign advance = ex_ready || !ex_valid;

    // Deliberately independent of id_valid: acceptance depends only on state and control
    assign id_ready   = !rst && advance && (branch_taken || (state == ST_FLUSH) || !hazard_stall);
    assign bubble_inc = !rst && advance && (branch_taken || (state == ST_FLUSH) || hazard_stall);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
            ex_valid  <= 1'b0;
            ex_q      <= '0;
        end else if (advance) begin
            if (branch_taken) begin
                ex_valid  <= 1'b0;
                ex_q      <= '0;
                flush_cnt <= FLUSH_INIT;
                state     <= BRANCH_ST;
            end else if (state == ST_FLUSH) begin
                ex_valid <= 1'b0;
                ex_q     <= '0;
                // Only a real instruction in ID counts as one of the killed slots
                if (id_valid) begin
                    flush_cnt <= flush_cnt - FLUSH_CNT_W'(1);
                    if (flush_cnt == FLUSH_CNT_W'(1)) begin
                        state <= ST_RUN;
                    end
                end
            end else if (hazard_stall) begin
                ex_valid <= 1'b0;
                ex_q     <= '0;
            end else begin
                ex_valid <= id_valid;
                ex_q     <= id_valid ? id_pl : '0;
            end
        end
    end

    assign ex_imm       = ex_q.imm;
    assign ex_op1       = ex_q.op1;
    assign ex_op2       = ex_q.op2;
    assign ex_alu_ctrl  = ex_q.alu_ctrl;
    assign ex_rout2     = ex_q.rout2;
    assign ex_func3     = ex_q.func3;
    assign ex_imm_fmt   = ex_q.imm_fmt;
    assign ex_rd        = ex_q.rd;
    assign ex_rs1_valid = ex_q.rs1_valid;
    assign ex_rs2_valid = ex_q.rs2_valid;
    assign ex_we        = ex_q.we;
    assign ex_wb_ctrl   = ex_q.wb_ctrl;

    sat_counter #(
        .W(CNT_W)
    ) u_bubble_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (bubble_inc),
        .count(bubble_cnt)
    );

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: directed vector table, hand sequences for reset and saturation,
// then random traffic against a reference model, on a 3-cycle-flush and a 1-cycle-flush instance.
module tb_id_ex_hazard_reg;
    import id_ex_hazard_reg_pkg::*;

    localparam int unsigned FC_A = 3;
    localparam int unsigned CW_A = 4;
    localparam int unsigned FC_B = 1;
    localparam int unsigned CW_B = 8;

    typedef struct packed {
        logic     rst;
        logic     id_valid;
        logic     bt;
        logic     hs;
        logic     ex_ready;
        payload_t pl;
    } stim_t;

    typedef struct {
        stim_t s;
        logic  exp_ready;
        logic  exp_valid;
        int    exp_rd;
        int    exp_cnt;
    } vec_t;

    typedef struct {
        bit       valid;
        payload_t pl;
        int       kills;
        int       bubbles;
    } model_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic     rst, id_valid, branch_taken, hazard_stall, ex_ready;
    payload_t in_pl;

    logic                  a_ready, a_valid, a_rs1, a_rs2, a_we;
    logic [DEF_DATA_W-1:0] a_imm, a_op1, a_op2, a_rout2;
    logic [DEF_ALU_W-1:0]  a_alu;
    logic [DEF_RD_W-1:0]   a_rd;
    logic [FUNC3_W-1:0]    a_func3;
    logic [IMM_FMT_W-1:0]  a_fmt;
    logic [WB_CTRL_W-1:0]  a_wb;
    logic [CW_A-1:0]       a_cnt;

    logic                  b_ready, b_valid, b_rs1, b_rs2, b_we;
    logic [DEF_DATA_W-1:0] b_imm, b_op1, b_op2, b_rout2;
    logic [DEF_ALU_W-1:0]  b_alu;
    logic [DEF_RD_W-1:0]   b_rd;
    logic [FUNC3_W-1:0]    b_func3;
    logic [IMM_FMT_W-1:0]  b_fmt;
    logic [WB_CTRL_W-1:0]  b_wb;
    logic [CW_B-1:0]       b_cnt;

    payload_t a_pl, b_pl;
    assign a_pl = {a_imm, a_op1, a_op2, a_alu, a_rout2, a_func3, a_fmt, a_rd, a_rs1, a_rs2, a_we, a_wb};
    assign b_pl = {b_imm, b_op1, b_op2, b_alu, b_rout2, b_func3, b_fmt, b_rd, b_rs1, b_rs2, b_we, b_wb};

    id_ex_hazard_reg #(
        .DATA_W(DEF_DATA_W), .RD_W(DEF_RD_W), .ALU_W(DEF_ALU_W),
        .FLUSH_CYCLES(FC_A), .CNT_W(CW_A)
    ) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(a_ready),
        .id_imm(in_pl.imm), .id_op1(in_pl.op1), .id_op2(in_pl.op2),
        .id_alu_ctrl(in_pl.alu_ctrl), .id_rout2(in_pl.rout2), .id_func3(in_pl.func3),
        .id_imm_fmt(in_pl.imm_fmt), .id_rd(in_pl.rd), .id_rs1_valid(in_pl.rs1_valid),
        .id_rs2_valid(in_pl.rs2_valid), .id_we(in_pl.we), .id_wb_ctrl(in_pl.wb_ctrl),
        .branch_taken(branch_taken), .hazard_stall(hazard_stall), .ex_ready(ex_ready),
        .ex_valid(a_valid), .ex_imm(a_imm), .ex_op1(a_op1), .ex_op2(a_op2),
        .ex_alu_ctrl(a_alu), .ex_rout2(a_rout2), .ex_func3(a_func3), .ex_imm_fmt(a_fmt),
        .ex_rd(a_rd), .ex_rs1_valid(a_rs1), .ex_rs2_valid(a_rs2), .ex_we(a_we),
        .ex_wb_ctrl(a_wb), .bubble_cnt(a_cnt)
    );

    id_ex_hazard_reg #(
        .DATA_W(DEF_DATA_W), .RD_W(DEF_RD_W), .ALU_W(DEF_ALU_W),
        .FLUSH_CYCLES(FC_B), .CNT_W(CW_B)
    ) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(b_ready),
        .id_imm(in_pl.imm), .id_op1(in_pl.op1), .id_op2(in_pl.op2),
        .id_alu_ctrl(in_pl.alu_ctrl), .id_rout2(in_pl.rout2), .id_func3(in_pl.func3),
        .id_imm_fmt(in_pl.imm_fmt), .id_rd(in_pl.rd), .id_rs1_valid(in_pl.rs1_valid),
        .id_rs2_valid(in_pl.rs2_valid), .id_we(in_pl.we), .id_wb_ctrl(in_pl.wb_ctrl),
        .branch_taken(branch_taken), .hazard_stall(hazard_stall), .ex_ready(ex_ready),
        .ex_valid(b_valid), .ex_imm(b_imm), .ex_op1(b_op1), .ex_op2(b_op2),
        .ex_alu_ctrl(b_alu), .ex_rout2(b_rout2), .ex_func3(b_func3), .ex_imm_fmt(b_fmt),
        .ex_rd(b_rd), .ex_rs1_valid(b_rs1), .ex_rs2_valid(b_rs2), .ex_we(b_we),
        .ex_wb_ctrl(b_wb), .bubble_cnt(b_cnt)
    );

    int errors = 0;
    int checks = 0;

    model_t ma, mb;

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference behaviour: EX either holds, takes a bubble, or takes the ID instruction
    function automatic logic model_ready(input model_t m, input stim_t s);
        bit adv;
        adv = s.ex_ready || !m.valid;
        return !s.rst && adv && (s.bt || (m.kills > 0) || !s.hs);
    endfunction

    function automatic model_t model_next(input model_t m, input stim_t s, input int fc, input int cmax);
        model_t n;
        bit     bubble;
        n = m;
        bubble = 1'b0;
        if (s.rst) begin
            n = '{valid: 1'b0, pl: PAYLOAD_BUBBLE, kills: 0, bubbles: 0};
            return n;
        end
        if (!(s.ex_ready || !m.valid)) return n;
        if (s.bt) begin
            bubble  = 1'b1;
            n.kills = fc - 1;
        end else if (m.kills > 0) begin
            bubble = 1'b1;
            if (s.id_valid) n.kills = m.kills - 1;
        end else if (s.hs) begin
            bubble = 1'b1;
        end else begin
            n.valid = s.id_valid;
            n.pl    = s.id_valid ? s.pl : PAYLOAD_BUBBLE;
        end
        if (bubble) begin
            n.valid   = 1'b0;
            n.pl      = PAYLOAD_BUBBLE;
            n.bubbles = (m.bubbles >= cmax) ? cmax : m.bubbles + 1;
        end
        return n;
    endfunction

    // One clock: drive, check id_ready mid-cycle, clock, check registered outputs
    task automatic step(input stim_t s, output logic rdy_a);
        rst          = s.rst;
        id_valid     = s.id_valid;
        branch_taken = s.bt;
        hazard_stall = s.hs;
        ex_ready     = s.ex_ready;
        in_pl        = s.pl;
        @(negedge clk);
        rdy_a = a_ready;
        check("a_id_ready", 160'(a_ready), 160'(model_ready(ma, s)));
        check("b_id_ready", 160'(b_ready), 160'(model_ready(mb, s)));
        @(posedge clk);
        ma = model_next(ma, s, int'(FC_A), (1 << CW_A) - 1);
        mb = model_next(mb, s, int'(FC_B), (1 << CW_B) - 1);
        #1;
        check("a_ex_valid", 160'(a_valid), 160'(ma.valid));
        check("a_ex_payload", 160'(a_pl), 160'(ma.pl));
        check("a_bubble_cnt", 160'(a_cnt), 160'(ma.bubbles));
        check("b_ex_valid", 160'(b_valid), 160'(mb.valid));
        check("b_ex_payload", 160'(b_pl), 160'(mb.pl));
        check("b_bubble_cnt", 160'(b_cnt), 160'(mb.bubbles));
    endtask

    function automatic payload_t mk(input int rd, input bit we);
        payload_t p;
        logic [31:0] r;
        r           = 32'(rd);
        p.imm       = 32'h1000 + r;
        p.op1       = r * 32'd3;
        p.op2       = ~r;
        p.alu_ctrl  = r[4:0];
        p.rout2     = 32'hA500_0000 | r;
        p.func3     = r[2:0];
        p.imm_fmt   = 7'h13;
        p.rd        = r[4:0];
        p.rs1_valid = 1'b1;
        p.rs2_valid = r[0];
        p.we        = we;
        p.wb_ctrl   = 2'b01;
        return p;
    endfunction

    function automatic stim_t st(input bit r, input bit v, input bit bt, input bit hs,
                                 input bit er, input int rd);
        stim_t s;
        s.rst = r; s.id_valid = v; s.bt = bt; s.hs = hs; s.ex_ready = er;
        s.pl  = mk(rd, 1'b1);
        return s;
    endfunction

    function automatic vec_t row(input stim_t s, input bit er, input bit ev, input int erd, input int ec);
        vec_t x;
        x.s = s; x.exp_ready = er; x.exp_valid = ev; x.exp_rd = erd; x.exp_cnt = ec;
        return x;
    endfunction

    vec_t  tbl[16];
    stim_t s;
    logic  rdy;

    initial begin
        ma = '{valid: 1'b0, pl: PAYLOAD_BUBBLE, kills: 0, bubbles: 0};
        mb = ma;
        rst = 1'b1; id_valid = 1'b0; branch_taken = 1'b0; hazard_stall = 1'b0;
        ex_ready = 1'b1; in_pl = PAYLOAD_BUBBLE;

        //              rst v  bt hs er rd        ready valid rd cnt   (instance with 3-cycle flush, 4-bit count)
        tbl[0]  = row(st(1, 0, 0, 0, 1, 0),  1'b0, 1'b0, 0,  0);
        tbl[1]  = row(st(0, 1, 0, 0, 1, 5),  1'b1, 1'b1, 5,  0);
        tbl[2]  = row(st(0, 1, 1, 0, 1, 6),  1'b1, 1'b0, 0,  1);
        tbl[3]  = row(st(0, 1, 0, 0, 1, 7),  1'b1, 1'b0, 0,  2);
        tbl[4]  = row(st(0, 1, 0, 0, 1, 8),  1'b1, 1'b0, 0,  3);
        tbl[5]  = row(st(0, 1, 0, 0, 1, 9),  1'b1, 1'b1, 9,  3);
        tbl[6]  = row(st(0, 1, 0, 1, 1, 10), 1'b0, 1'b0, 0,  4);
        tbl[7]  = row(st(0, 1, 0, 0, 1, 10), 1'b1, 1'b1, 10, 4);
        tbl[8]  = row(st(0, 1, 1, 1, 0, 11), 1'b0, 1'b1, 10, 4);
        tbl[9]  = row(st(0, 1, 1, 1, 0, 11), 1'b0, 1'b1, 10, 4);
        tbl[10] = row(st(0, 1, 1, 0, 1, 11), 1'b1, 1'b0, 0,  5);
        tbl[11] = row(st(0, 0, 0, 0, 1, 0),  1'b1, 1'b0, 0,  6);
        tbl[12] = row(st(1, 1, 0, 0, 1, 12), 1'b0, 1'b0, 0,  0);
        tbl[13] = row(st(0, 1, 0, 0, 1, 13), 1'b1, 1'b1, 13, 0);
        tbl[14] = row(st(0, 0, 0, 0, 1, 0),  1'b1, 1'b0, 0,  0);
        tbl[15] = row(st(0, 1, 0, 0, 0, 14), 1'b1, 1'b1, 14, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].s, rdy);
            check($sformatf("vec%0d_id_ready", i), 160'(rdy), 160'(tbl[i].exp_ready));
            check($sformatf("vec%0d_ex_valid", i), 160'(a_valid), 160'(tbl[i].exp_valid));
            check($sformatf("vec%0d_ex_rd", i), 160'(a_rd), 160'(tbl[i].exp_rd));
            check($sformatf("vec%0d_bubble_cnt", i), 160'(a_cnt), 160'(tbl[i].exp_cnt));
        end

        // With a single-cycle flush, the instruction right after the branch loads directly
        step(st(1, 0, 0, 0, 1, 0), rdy);
        step(st(0, 1, 1, 0, 1, 20), rdy);
        step(st(0, 1, 0, 0, 1, 21), rdy);
        check("fc1_next_valid", 160'(b_valid), 160'(1));
        check("fc1_next_rd", 160'(b_rd), 160'(21));
        check("fc1_bubble_cnt", 160'(b_cnt), 160'(1));
        check("fc3_still_flushing", 160'(a_valid), 160'(0));

        // Twenty back-to-back stall bubbles saturate the 4-bit counter
        step(st(1, 0, 0, 0, 1, 0), rdy);
        for (int i = 0; i < 20; i++) step(st(0, 1, 0, 1, 1, 22), rdy);
        check("sat_a_cnt", 160'(a_cnt), 160'(15));
        check("sat_b_cnt", 160'(b_cnt), 160'(20));
        step(st(0, 1, 0, 0, 1, 22), rdy);
        check("sat_a_hold", 160'(a_cnt), 160'(15));
        check("sat_after_load_rd", 160'(a_rd), 160'(22));

        // Random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            s.rst          = ($urandom_range(0, 59) == 0);
            s.id_valid     = ($urandom_range(0, 3) != 0);
            s.bt           = ($urandom_range(0, 5) == 0);
            s.hs           = ($urandom_range(0, 4) == 0);
            s.ex_ready     = ($urandom_range(0, 3) != 0);
            s.pl.imm       = $urandom;
            s.pl.op1       = $urandom;
            s.pl.op2       = $urandom;
            s.pl.alu_ctrl  = 5'($urandom);
            s.pl.rout2     = $urandom;
            s.pl.func3     = 3'($urandom);
            s.pl.imm_fmt   = 7'($urandom);
            s.pl.rd        = 5'($urandom);
            s.pl.rs1_valid = 1'($urandom);
            s.pl.rs2_valid = 1'($urandom);
            s.pl.we        = 1'($urandom);
            s.pl.wb_ctrl   = 2'($urandom);
            step(s, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
